// File: rtl/rb_sched_pkg.sv
// rtl/rb_sched_pkg.sv - shared constants, state type and helpers for the queue scheduler
package rb_sched_pkg;

  localparam int NCHAN     = 8;
  localparam int CHW       = 3;
  localparam int CNTW      = 8;
  localparam int DW        = 64;
  localparam int DEF_BURST = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Smaller of two occupancy-width values; sizes a burst from queue depth and the cap.
  function automatic logic [CNTW-1:0] min_cnt(input logic [CNTW-1:0] a,
                                               input logic [CNTW-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rb_rr_pick.sv
// rtl/rb_rr_pick.sv - combinational first-set-bit search starting at a rotating pointer
module rb_rr_pick
  import rb_sched_pkg::*;
(
  input  logic [NCHAN-1:0] vec,
  input  logic [CHW-1:0]   start,
  output logic [CHW-1:0]   idx,
  output logic             found
);

  logic [CHW-1:0] cand;

  // Walk the channels from start upward, wrapping naturally in CHW-bit arithmetic.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NCHAN; k++) begin
      cand = start + CHW'(k);
      if (!found && vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rb_queue_sched.sv
// rtl/rb_queue_sched.sv - round-robin burst scheduler draining eight request queues to one stream
module rb_queue_sched
  import rb_sched_pkg::NCHAN, rb_sched_pkg::CHW, rb_sched_pkg::CNTW, rb_sched_pkg::DW,
         rb_sched_pkg::DEF_BURST, rb_sched_pkg::state_t, rb_sched_pkg::IDLE,
         rb_sched_pkg::min_cnt;
#(
  parameter int BURST = DEF_BURST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_en,
  input  logic [NCHAN-1:0]      chan_mask,
  input  logic [NCHAN*CNTW-1:0] req_count,
  output logic [CHW-1:0]        req_addr,
  output logic                  req_read,
  input  logic [DW-1:0]         req_data,
  output logic                  out_valid,
  output logic [DW-1:0]         out_data,
  output logic [CHW-1:0]        out_chan,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam logic [CNTW-1:0] BURST_LEN = CNTW'(BURST);

  state_t          state;
  logic [CHW-1:0]  rr_ptr;
  logic [CHW-1:0]  grant;
  logic [CNTW-1:0] left;

  logic [NCHAN-1:0] eligible;
  logic [CHW-1:0]   pick_idx;
  logic             pick_found;
  logic [CNTW-1:0]  pick_cnt;

  // A channel competes only when unmasked and its queue holds at least one word.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NCHAN; i++) begin
      eligible[i] = chan_mask[i] && (req_count[i*CNTW +: CNTW] != '0);
    end
  end

  rb_rr_pick u_pick (
    .vec   (eligible),
    .start (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign pick_cnt = req_count[32'(pick_idx)*CNTW +: CNTW];

  // Pop whenever the output register is empty or being drained this cycle.
  assign busy     = (state == rb_sched_pkg::BURST);
  assign req_read = busy && (!out_valid || out_ready);

  // Scheduler FSM plus the output register; the burst length is frozen at grant time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      left      <= '0;
      req_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_en && pick_found) begin
            grant    <= pick_idx;
            req_addr <= pick_idx;
            left     <= min_cnt(pick_cnt, BURST_LEN);
            state    <= rb_sched_pkg::BURST;
          end
        end
        rb_sched_pkg::BURST: begin
          if (req_read) begin
            left <= left - 1'b1;
            if (left == CNTW'(1)) begin
              state  <= IDLE;
              rr_ptr <= grant + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (req_read) begin
        out_data  <= req_data;
        out_chan  <= grant;
        out_last  <= (left == CNTW'(1));
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rb_queue_sched.sv
// tb/tb_rb_queue_sched.sv - directed self-checking bench for the round-robin queue scheduler
module tb_rb_queue_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_en = 1'b0;
  logic [7:0]  chan_mask = 8'h00;
  logic [63:0] req_count;
  logic [2:0]  req_addr;
  logic        req_read;
  logic [63:0] req_data;
  logic        out_valid;
  logic [63:0] out_data;
  logic [2:0]  out_chan;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Queue model: remaining words = base - popped; head word encodes {channel, sequence}.
  int base    [8];
  int popped  [8];
  int exp_seq [8];
  int pop_total = 0;
  int bad_pop   = 0;

  rb_queue_sched #(.BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_en    (cfg_en),
    .chan_mask (chan_mask),
    .req_count (req_count),
    .req_addr  (req_addr),
    .req_read  (req_read),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_count = '0;
    for (int i = 0; i < 8; i++) begin
      req_count[i*8 +: 8] = 8'(((base[i] - popped[i]) > 255) ? 255 : (base[i] - popped[i]));
    end
  end

  assign req_data = {5'd0, req_addr, 24'd0, 32'(popped[req_addr])};

  always @(posedge clk) begin
    if (req_read) begin
      popped[req_addr] <= popped[req_addr] + 1;
      pop_total        <= pop_total + 1;
      if (base[req_addr] - popped[req_addr] <= 0) bad_pop <= bad_pop + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (req_read && !busy) begin
        n_fail++;
        $display("FAIL read_in_idle: got req_read=1 expected 0 at %0t", $time);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    cfg_en    = 1'b0;
    chan_mask = 8'h00;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      base[i]    = popped[i];
      exp_seq[i] = popped[i];
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_cnt(input int ch, input int n);
    base[ch] = popped[ch] + n;
  endtask

  // Caller sits on a negedge; gathers one burst and returns on the negedge after its last word.
  task automatic collect(output int n, output int ch);
    int t = 0;
    bit done = 0;
    n  = 0;
    ch = -1;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL collect_timeout: got no out_valid expected a burst");
      return;
    end
    ch = int'(out_chan);
    t  = 0;
    while (!done && t < 300) begin
      if (out_valid) begin
        check("burst_chan", 64'(out_chan), 64'(ch));
        check("word_data", out_data, {5'd0, out_chan, 24'd0, 32'(exp_seq[out_chan])});
        exp_seq[out_chan]++;
        n++;
        if (out_last) done = 1;
      end
      @(negedge clk);
      t++;
    end
  endtask

  typedef struct packed {
    logic        en;
    logic [7:0]  mask;
    logic [63:0] cnts;
    logic [2:0]  exp_ch;
    logic [7:0]  exp_n;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int n, ch, p0, hold_t, t_first, t_last, k;
    logic [63:0] hold;
    int order [8];

    for (int i = 0; i < 8; i++) begin
      base[i] = 0; popped[i] = 0; exp_seq[i] = 0;
    end

    tbl[0] = '{1'b1, 8'hFF, 64'h0000_0000_0600_0000, 3'd3, 8'd4};
    tbl[1] = '{1'b1, 8'h04, 64'h0000_0000_0002_0200, 3'd2, 8'd2};
    tbl[2] = '{1'b1, 8'hFF, 64'h0000_0000_0000_0003, 3'd0, 8'd3};
    tbl[3] = '{1'b1, 8'hFF, 64'h0100_0000_0000_0000, 3'd7, 8'd1};
    tbl[4] = '{1'b1, 8'hFE, 64'h0000_0900_0000_0005, 3'd5, 8'd4};
    tbl[5] = '{1'b1, 8'hFF, 64'h0000_0000_0000_FF00, 3'd1, 8'd4};
    tbl[6] = '{1'b0, 8'hFF, 64'h0000_0000_0003_0000, 3'd0, 8'd0};
    tbl[7] = '{1'b1, 8'h00, 64'h0000_0004_0000_0000, 3'd0, 8'd0};

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_busy",      64'(busy), 0);
    check("rst_req_read",  64'(req_read), 0);
    check("rst_req_addr",  64'(req_addr), 0);
    check("rst_out_data",  out_data, 0);
    check("rst_out_chan",  64'(out_chan), 0);
    check("rst_out_last",  64'(out_last), 0);

    // Table: first burst after reset for each mask/count/enable pattern
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int i = 0; i < 8; i++) set_cnt(i, int'(tbl[v].cnts[i*8 +: 8]));
      p0 = pop_total;
      chan_mask = tbl[v].mask;
      cfg_en    = tbl[v].en;
      if (tbl[v].exp_n != 0) begin
        collect(n, ch);
        check($sformatf("tbl%0d_chan", v), 64'(ch), 64'(tbl[v].exp_ch));
        check($sformatf("tbl%0d_words", v), 64'(n), 64'(tbl[v].exp_n));
      end else begin
        repeat (20) @(negedge clk);
        check($sformatf("tbl%0d_pops", v), 64'(pop_total - p0), 0);
        check($sformatf("tbl%0d_busy", v), 64'(busy), 0);
        check($sformatf("tbl%0d_rr_ptr", v), 64'(dut.rr_ptr), 0);
      end
    end

    // Single channel longer than the cap: 4 words, one idle cycle, 2 words
    do_reset();
    set_cnt(3, 6);
    chan_mask = 8'hFF;
    cfg_en    = 1'b1;
    collect(n, ch);
    check("single_b1_chan", 64'(ch), 3);
    check("single_b1_words", 64'(n), 4);
    check("single_gap", 64'(out_valid), 0);
    collect(n, ch);
    check("single_b2_chan", 64'(ch), 3);
    check("single_b2_words", 64'(n), 2);
    check("single_rr_ptr", 64'(dut.rr_ptr), 4);

    // Round robin over eight single-word queues, with latency and total span
    do_reset();
    for (int i = 0; i < 8; i++) set_cnt(i, 1);
    chan_mask = 8'hFF;
    cfg_en    = 1'b1;
    k = 0; t_first = -1; t_last = -1;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (t == 1) check("rr_busy_after_grant", 64'(busy), 1);
      if (out_valid && k < 8) begin
        if (t_first < 0) t_first = t;
        order[k] = int'(out_chan);
        check("rr_last", 64'(out_last), 1);
        check("rr_data", out_data, {5'd0, out_chan, 24'd0, 32'(exp_seq[out_chan])});
        exp_seq[out_chan]++;
        if (k == 7) t_last = t;
        k++;
      end
    end
    check("rr_words", 64'(k), 8);
    for (int i = 0; i < 8; i++) check($sformatf("rr_order%0d", i), 64'(order[i]), 64'(i));
    check("rr_first_latency", 64'(t_first), 2);
    check("rr_span", 64'(t_last), 16);

    // Backpressure: hold the first word for 5 cycles
    do_reset();
    set_cnt(0, 3);
    p0 = pop_total;
    chan_mask = 8'hFF;
    cfg_en    = 1'b1;
    hold_t = 0;
    while (!out_valid && hold_t < 40) begin
      @(negedge clk);
      hold_t++;
    end
    check("bp_started", 64'(out_valid), 1);
    out_ready = 1'b0;
    hold = out_data;
    repeat (5) begin
      @(negedge clk);
      check("bp_stable", out_data, hold);
      check("bp_valid", 64'(out_valid), 1);
      check("bp_outstanding", 64'(pop_total - p0), 1);
    end
    out_ready = 1'b1;
    collect(n, ch);
    check("bp_words", 64'(n), 3);
    check("bp_total_pops", 64'(pop_total - p0), 3);

    // Reset during the second word of a 4-word burst
    do_reset();
    set_cnt(0, 10);
    chan_mask = 8'hFF;
    cfg_en    = 1'b1;
    hold_t = 0;
    while (!out_valid && hold_t < 40) begin
      @(negedge clk);
      hold_t++;
    end
    @(negedge clk);
    check("mid_second_word", 64'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 0);
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_read", 64'(req_read), 0);
    @(negedge clk);
    exp_seq[0] = popped[0];
    rst = 1'b0;
    @(negedge clk);
    check("mid_regrant_busy", 64'(busy), 1);
    check("mid_regrant_addr", 64'(req_addr), 0);
    collect(n, ch);
    check("mid_regrant_chan", 64'(ch), 0);
    check("mid_regrant_words", 64'(n), 4);

    // Wrap: move rr_ptr to 7, then only ch1 is eligible
    do_reset();
    set_cnt(6, 1);
    chan_mask = 8'hFF;
    cfg_en    = 1'b1;
    collect(n, ch);
    check("wrap_pre_chan", 64'(ch), 6);
    check("wrap_pre_rr_ptr", 64'(dut.rr_ptr), 7);
    set_cnt(1, 1);
    collect(n, ch);
    check("wrap_chan", 64'(ch), 1);
    check("wrap_words", 64'(n), 1);
    check("wrap_rr_ptr", 64'(dut.rr_ptr), 2);

    check("no_pop_when_empty", 64'(bad_pop), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
